// File: rtl/div_pkg.sv
// Shared widths, run length, state encoding and saturation value for the
// divider issue controller.
package div_pkg;
   localparam int A_WIDTH    = 21;
   localparam int B_WIDTH    = 13;
   localparam int Q_WIDTH    = 8;
   localparam int RUN_CYCLES = A_WIDTH + 5;
   localparam int CNT_WIDTH  = $clog2(RUN_CYCLES + 1);

   localparam logic [Q_WIDTH-1:0] Q_SAT = {Q_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;
endpackage

// File: rtl/div_issue_ctrl.sv
// Request/response front end for the sequential divider core: latches operands,
// loads and runs the core for a fixed count, resolves dz/overflow up front.
module div_issue_ctrl
   import div_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_WIDTH-1:0] in_dividend,
   input  logic [B_WIDTH-1:0] in_divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [Q_WIDTH-1:0] out_quotient,
   output logic               out_dz,
   output logic               out_ovf,
   output logic               core_rst,
   output logic               core_en,
   output logic [A_WIDTH-1:0] core_dividend,
   output logic [B_WIDTH-1:0] core_divisor,
   input  logic [Q_WIDTH-1:0] core_quotient,
   output logic [1:0]         dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid and its payload stay stable until that edge.

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [Q_WIDTH-1:0]   quot_q, quot_d;
   logic                 dz_q, dz_d;
   logic                 ovf_q, ovf_d;
   logic                 valid_q, valid_d;
   logic [A_WIDTH-1:0]   dividend_q, dividend_d;
   logic [B_WIDTH-1:0]   divisor_q, divisor_d;
   logic [B_WIDTH-1:0]   dividend_hi;

   // Quotient overflows exactly when dividend / 2**Q_WIDTH >= divisor.
   assign dividend_hi = in_dividend[A_WIDTH-1:Q_WIDTH];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      dz_d       = dz_q;
      ovf_d      = ovf_q;
      valid_d    = valid_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               dividend_d = in_dividend;
               divisor_d  = in_divisor;
               if (in_divisor == '0) begin
                  quot_d  = Q_SAT;
                  dz_d    = 1'b1;
                  ovf_d   = 1'b0;
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end else if (dividend_hi >= in_divisor) begin
                  quot_d  = Q_SAT;
                  dz_d    = 1'b0;
                  ovf_d   = 1'b1;
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            // The core result is only settled on the last enabled cycle.
            if (cnt_q == CNT_WIDTH'(RUN_CYCLES - 1)) begin
               quot_d  = core_quotient;
               dz_d    = 1'b0;
               ovf_d   = 1'b0;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         quot_q     <= '0;
         dz_q       <= 1'b0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         quot_q     <= quot_d;
         dz_q       <= dz_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
      end
   end

   assign in_ready      = (state_q == ST_IDLE);
   assign core_rst      = rst | (state_q == ST_IDLE) | (state_q == ST_LOAD);
   assign core_en       = (state_q == ST_RUN);
   assign out_valid     = valid_q;
   assign out_quotient  = quot_q;
   assign out_dz        = dz_q;
   assign out_ovf       = ovf_q;
   assign core_dividend = dividend_q;
   assign core_divisor  = divisor_q;
   assign dbg_state     = state_q;

endmodule
